sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock synchronous FIFO built on a 2**ADDR_WIDTH-entry register-file buffer, with circular read/write pointers and full/empty status flags.
- Used as a general-purpose rate/latency decoupling buffer between two agents in the same clock domain.
- Output data is first-word-fall-through: r_data always presents the head entry, with no read latency.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH entries (test configuration: 3, i.e. depth 8).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- wr  input  1  write request; w_data is pushed on the clk rising edge when accepted.
- rd  input  1  read request; head entry is popped on the clk rising edge when accepted.
- w_data  input  DATA_WIDTH  write data.
- r_data  output  DATA_WIDTH  head-of-FIFO data, combinational from buffer[r_ptr].
- full  output  1  asserted when the FIFO holds 2**ADDR_WIDTH entries.
- empty  output  1  asserted when the FIFO holds 0 entries.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-operation):
  - w_ptr=0, r_ptr=0, full=0, empty=1.
  - Buffer contents are not cleared; r_data is don't-care while empty.
  - Release is synchronised to the next rising edge by design use; there is no internal synchroniser.
- Registered state: w_ptr, r_ptr (ADDR_WIDTH bits each), full_reg, empty_reg. full and empty are driven directly from these registers (no combinational path from rd/wr).
- Pointer increments are modulo 2**ADDR_WIDTH; wrap-around is natural binary rollover.
- wr_en = wr & (~full | rd). rd_en = rd & ~empty.
- Per clock edge, keyed on {wr, rd}:
  - 00: no change.
  - 01, not empty: r_ptr++; full<=0; empty<=1 if r_ptr+1==w_ptr.
  - 01, empty: ignored; no state change (underflow suppressed).
  - 10, not full: buffer[w_ptr]<=w_data; w_ptr++; empty<=0; full<=1 if w_ptr+1==r_ptr.
  - 10, full: ignored; buffer unchanged (overflow suppressed).
  - 11, empty: write only; empty<=0 next cycle and r_data shows w_data from that point. The read is ignored.
  - 11, full: write into the freed slot and pop; both pointers advance; full stays 1.
  - 11, otherwise: both pointers advance; flags unchanged.
- Latency:
  - Written data is visible on r_data one edge after the write into an empty FIFO.
  - r_data changes combinationally after r_ptr advances.
- full and empty are never asserted simultaneously.

Optional Feature:
- Macro SYNC_FIFO_LEVEL_EN.
- When defined:
  - Adds output port level [ADDR_WIDTH:0], the registered occupancy count 0..2**ADDR_WIDTH.
  - level resets to 0.
  - level increments on an accepted write alone, decrements on an accepted read alone, and is unchanged when both are accepted.
  - level always equals the number of stored entries; full==(level==2**ADDR_WIDTH) and empty==(level==0).
- When undefined: no level port and no count register; the flags come from pointer comparison only.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3):
- Reset low then high -> empty=1, full=0. Write 5, 8, 2 -> empty=0 after the first write; r_data=5. One read -> r_data=8.
- From 2 entries, write 0, 9, 3, 6, 1, 3 -> full=1 after the 8th stored entry. A further write of 0xAA while full -> ignored; contents unchanged.
- From full, read 8 times -> r_data sequence 8, 2, 0, 9, 3, 6, 1, 3. empty=1 after the last read; pointers have wrapped.
- While empty, rd=1 and wr=1 with w_data=7 -> write only; next cycle empty=0 and r_data=7. Then rd alone -> empty=1. Then rd while empty -> no change; empty stays 1.
- Write 4, 5, 6, then rd=wr=1 with w_data=7 -> head pops (r_data becomes 5); 7 is appended; occupancy stays 3 (level=3 when SYNC_FIFO_LEVEL_EN); reading out gives 5, 6, 7.
- Assert reset mid-stream with 4 entries -> empty=1 and full=0 immediately, without waiting for a clock edge. The next write of 0x11 is read back as 0x11.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with registered full/empty flags.
// Define SYNC_FIFO_LEVEL_EN to add a registered occupancy output named level.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
`ifdef SYNC_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0]   level,
`endif
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr, w_next, r_next;
  logic full_reg, empty_reg, wr_en, rd_en;
  assign w_next = w_ptr + 1'b1;
  assign r_next = r_ptr + 1'b1;
  // a full FIFO still accepts a write when the same edge frees the head slot
  assign wr_en  = wr & (~full_reg | rd);
  assign rd_en  = rd & ~empty_reg;
  assign r_data = mem[r_ptr];
  assign full   = full_reg;
  assign empty  = empty_reg;
  always_ff @(posedge clk)
    if (wr_en) mem[w_ptr] <= w_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      if (wr_en) w_ptr <= w_next;
      if (rd_en) r_ptr <= r_next;
      if (wr_en && !rd_en) begin
        empty_reg <= 1'b0;
        full_reg  <= (w_next == r_ptr);
      end else if (rd_en && !wr_en) begin
        full_reg  <= 1'b0;
        empty_reg <= (r_next == w_ptr);
      end
    end
  end
`ifdef SYNC_FIFO_LEVEL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) level <= '0;
    else if (wr_en && !rd_en) level <= level + 1'b1;
    else if (rd_en && !wr_en) level <= level - 1'b1;
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo at depth 8.
module tb_sync_fifo;
  logic clk = 1'b0, reset = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] w_data = '0, r_data;
  logic full, empty;
  int checks = 0, failures = 0;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [3:0] level;
`endif

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .w_data(w_data),
    .r_data(r_data), .full(full),
`ifdef SYNC_FIFO_LEVEL_EN
    .level(level),
`endif
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; w_data = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL post_reset_empty got=%b exp=1", empty); end
  endtask

  task automatic test_write_read;
    cycle(1, 0, 8'd5);
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL first_write_empty got=%b exp=0", empty); end
    checks++; if (r_data !== 8'd5) begin failures++; $display("FAIL first_write_data got=%0d exp=5", r_data); end
    cycle(1, 0, 8'd8);
    cycle(1, 0, 8'd2);
    checks++; if (r_data !== 8'd5) begin failures++; $display("FAIL head_after_3 got=%0d exp=5", r_data); end
    cycle(0, 1, 8'd0);
    checks++; if (r_data !== 8'd8) begin failures++; $display("FAIL head_after_pop got=%0d exp=8", r_data); end
  endtask

  task automatic test_fill_overflow;
    logic [7:0] v [6] = '{8'd0, 8'd9, 8'd3, 8'd6, 8'd1, 8'd3};
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, v[i]);
      checks++;
      if (full !== (i == 5)) begin failures++; $display("FAIL fill_full_%0d got=%b exp=%b", i, full, i == 5); end
    end
`ifdef SYNC_FIFO_LEVEL_EN
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL full_level got=%0d exp=8", level); end
`endif
    cycle(1, 0, 8'hAA);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL overflow_full got=%b exp=1", full); end
    checks++; if (r_data !== 8'd8) begin failures++; $display("FAIL overflow_head got=%0d exp=8", r_data); end
  endtask

  task automatic test_drain;
    logic [7:0] e [8] = '{8'd8, 8'd2, 8'd0, 8'd9, 8'd3, 8'd6, 8'd1, 8'd3};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r_data !== e[i]) begin failures++; $display("FAIL drain_%0d got=%0d exp=%0d", i, r_data, e[i]); end
      cycle(0, 1, 8'd0);
      checks++;
      if (full !== 1'b0) begin failures++; $display("FAIL drain_full_%0d got=%b exp=0", i, full); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simul_empty;
    cycle(1, 1, 8'd7);
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL rw_empty_flag got=%b exp=0", empty); end
    checks++; if (r_data !== 8'd7) begin failures++; $display("FAIL rw_empty_data got=%0d exp=7", r_data); end
    cycle(0, 1, 8'd0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pop_last_empty got=%b exp=1", empty); end
    cycle(0, 1, 8'd0);
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL underflow got=%b%b exp=10", empty, full); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e [3] = '{8'd5, 8'd6, 8'd7};
    cycle(1, 0, 8'd4); cycle(1, 0, 8'd5); cycle(1, 0, 8'd6);
    cycle(1, 1, 8'd7);
    checks++; if (r_data !== 8'd5) begin failures++; $display("FAIL b2b_head got=%0d exp=5", r_data); end
`ifdef SYNC_FIFO_LEVEL_EN
    checks++; if (level !== 4'd3) begin failures++; $display("FAIL b2b_level got=%0d exp=3", level); end
`endif
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (r_data !== e[i]) begin failures++; $display("FAIL b2b_read_%0d got=%0d exp=%0d", i, r_data, e[i]); end
      cycle(0, 1, 8'd0);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 8; i++) cycle(1, 0, 8'(8'h20 + i));
    cycle(1, 1, 8'hEE);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_rw_flag got=%b exp=1", full); end
    checks++; if (r_data !== 8'h21) begin failures++; $display("FAIL full_rw_head got=%h exp=21", r_data); end
    for (int i = 0; i < 7; i++) cycle(0, 1, 8'd0);
    checks++; if (r_data !== 8'hEE) begin failures++; $display("FAIL full_rw_tail got=%h exp=ee", r_data); end
    cycle(0, 1, 8'd0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_rw_empty got=%b exp=1", empty); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'(8'h40 + i));
    #3 reset = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL async_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL async_full got=%b exp=0", full); end
`ifdef SYNC_FIFO_LEVEL_EN
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL async_level got=%0d exp=0", level); end
`endif
    @(negedge clk) reset = 1'b1;
    cycle(1, 0, 8'h11);
    checks++; if (r_data !== 8'h11 || empty !== 1'b0) begin failures++; $display("FAIL post_async got=%h/%b exp=11/0", r_data, empty); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_fill_overflow;
    test_drain;
    test_simul_empty;
    test_back_to_back;
    test_full_rw;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
